regfile_wb_arbiter: RTL

Write-port controller for the 32x32 register file. It shares the register file's single write port (RegWrite/WR/WD) between two writeback requesters, A (ALU result) and B (load data), using valid/ready handshakes and round-robin arbitration. After every reset it first runs a clear sequence that zeroes every register. It sits between the datapath writeback stage and the register file's write inputs; the read ports are not touched.

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between an ALU (A) and a load (B) requester.
// After each reset it first sweeps every register to zero, then arbitrates round-robin.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              init_done,
    output logic              dbg_state
);

    // Handshake: a write transfers on any cycle where valid && ready. Ready is
    // combinational from state, both valids and prio only; the requester must
    // hold addr/data stable while valid is high and ready is low.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                prio_q, prio_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
    logic                init_done_q, init_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            rf_wd_q     <= rf_wd_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        rf_we_d     = 1'b0;
        rf_wa_d     = rf_wa_q;
        rf_wd_d     = rf_wd_q;
        init_done_d = init_done_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;

        case (state_q)
            ST_INIT: begin
                rf_we_d = 1'b1;
                rf_wa_d = cnt_q;
                rf_wd_d = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                a_ready = a_valid && (!b_valid || !prio_q);
                b_ready = b_valid && (!a_valid || prio_q);
                // Pointer only moves on contention; single-valid grants leave it alone.
                if (a_valid && b_valid) begin
                    prio_d = !prio_q;
                end
                // r0 is hardwired zero: accept the handshake but drop the write.
                if (a_ready && (a_addr != '0)) begin
                    rf_we_d = 1'b1;
                    rf_wa_d = a_addr;
                    rf_wd_d = a_data;
                end else if (b_ready && (b_addr != '0)) begin
                    rf_we_d = 1'b1;
                    rf_wa_d = b_addr;
                    rf_wd_d = b_data;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign init_done = init_done_q;
    assign dbg_state = state_q;

endmodule
